tx_pll_lock_sequencer: RTL and testbench
========================================

Name: tx_pll_lock_sequencer

Overview:
Sequences bring-up of the transceiver TX PLL and its lane. Holds the PLL/lane in reset, waits for lock with a timeout, and qualifies lock as stable. It then releases the lane and monitors for loss of lock, with bounded automatic retries. It sits in the fabric clock domain between the system reset/enable logic and the TX PLL lock outputs and the lane reset inputs.

Parameters:
RST_HOLD_CYCLES, 64, CLK cycles PLL_RST is held asserted per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max CLK cycles in WAIT_LOCK before the attempt fails (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive CLK cycles of qualified lock required before READY (>=1)
MAX_RETRIES, 7, failed attempts allowed before FAILED (0..15)

Ports:
CLK  in  1  fabric clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  level; 1 = run sequence, 0 = return to IDLE and hold reset
PLL_LOCK  in  1  PLL fabric lock, asynchronous to CLK
LOCK  in  1  PLL lock to lane, asynchronous to CLK
RETRY_CLR  in  1  single-cycle pulse; clears the retry counter and leaves FAILED
PLL_RST  out  1  active-high reset to PLL/lane datapath
LANE_RST_N  out  1  active-low lane release; 1 only in READY
TX_READY  out  1  1 only in READY
LOCK_LOST  out  1  one-cycle pulse on READY -> PLL_RESET due to lock loss
FAILED  out  1  1 only in FAILED
RETRY_CNT  out  4  failed attempts since last clear, saturating at 15
STATE  out  3  current state encoding, for debug

Behaviour:
- Synchronisation: PLL_LOCK and LOCK each pass through a 2-flop synchroniser (reset value 0). qlock = sync(PLL_LOCK) AND sync(LOCK). All decisions use qlock, so there are 2 cycles of input latency.
- Reset values: STATE=IDLE, PLL_RST=1, LANE_RST_N=0, TX_READY=0, LOCK_LOST=0, FAILED=0, RETRY_CNT=0, and all counters 0.
- States and encodings: IDLE=0, PLL_RESET=1, WAIT_LOCK=2, STABLE=3, READY=4, FAILED=5. Values 6 and 7 are unreachable and recover to IDLE on the next cycle.
- A single down-counter cnt (width = clog2 of the largest parameter + 1) is reloaded on every state entry.
- IDLE: PLL_RST=1. If ENABLE=1, go to PLL_RESET with cnt=RST_HOLD_CYCLES-1.
- PLL_RESET: PLL_RST=1. When cnt=0, go to WAIT_LOCK with cnt=LOCK_TIMEOUT_CYCLES-1. Otherwise decrement. Duration is exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK: PLL_RST=0.
  - If qlock=1, go to STABLE with cnt=LOCK_STABLE_CYCLES-1.
  - Otherwise, if cnt=0 (timeout), RETRY_CNT increments (saturating). If the pre-increment RETRY_CNT >= MAX_RETRIES, go to FAILED; else go to PLL_RESET.
  - qlock=1 on the timeout cycle takes priority: go to STABLE.
- STABLE: PLL_RST=0.
  - qlock=0 on any cycle goes to WAIT_LOCK with cnt reloaded to LOCK_TIMEOUT_CYCLES-1. This is a glitch, not a failure; RETRY_CNT is unchanged.
  - When cnt=0 with qlock=1, go to READY.
  - READY is entered exactly LOCK_STABLE_CYCLES cycles after STABLE entry.
- READY: TX_READY=1, LANE_RST_N=1, PLL_RST=0. If qlock=0, go to PLL_RESET, pulse LOCK_LOST for 1 cycle (registered, concurrent with the first PLL_RESET cycle), and increment RETRY_CNT.
- FAILED: FAILED=1, PLL_RST=1. Stays until RETRY_CLR=1, which goes to IDLE with RETRY_CNT=0.
- ENABLE=0 in any state except FAILED: next state is IDLE. It has priority over all other transitions, including a LOCK_LOST event, so no pulse is generated. ENABLE=0 in FAILED is ignored.
- RETRY_CLR in states other than FAILED: clears RETRY_CNT only; there is no state change. If it coincides with an increment, the clear wins.
- RESET asserted mid-sequence: on the next edge, all outputs return to reset values regardless of state.
- All outputs are registered (decoded from next state). There are no combinational input-to-output paths.

Test Plan:
1. RESET, ENABLE=1, locks tied 1 from start, RST_HOLD=4, STABLE=8: PLL_RST high for 4 cycles after IDLE exit; READY/TX_READY=1 exactly 4+1+8 cycles after PLL_RESET entry; RETRY_CNT=0.
2. Locks held 0, TIMEOUT=16, MAX_RETRIES=2:
   - Three full reset+wait attempts, then FAILED=1 with RETRY_CNT=3 and PLL_RST=1.
   - RETRY_CLR pulse returns the block to IDLE with RETRY_CNT=0.
3. In STABLE, drop LOCK for 1 cycle at stable cycle 5: the block returns to WAIT_LOCK with no retry increment. Once lock is restored, READY arrives a full LOCK_STABLE_CYCLES later.
4. In READY, drop PLL_LOCK: after 2 sync cycles TX_READY=0 and LOCK_LOST pulses exactly 1 cycle. PLL_RST=1 for RST_HOLD_CYCLES and RETRY_CNT goes 0->1.
5. ENABLE=0 in the same cycle qlock falls in READY: the next state is IDLE and LOCK_LOST stays 0. With ENABLE=0 in FAILED, the block remains FAILED.
6. RESET asserted for 1 cycle mid-WAIT_LOCK with RETRY_CNT=2: the next cycle shows STATE=0, PLL_RST=1 and RETRY_CNT=0. The sequence then restarts normally.

Source files
------------

// File: rtl/tx_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tx_pll_lock_sequencer
//
// Brings up the transceiver TX PLL and its lane. The PLL/lane is held in
// reset, then the block waits for lock with a timeout and requires lock to
// stay up for a qualification window before the lane is released. Once the
// lane is up, a loss of lock sends the block back through a new reset attempt.
// Failed attempts are counted, and after too many the block parks in FAILED
// until software clears it.
//
// State | meaning
// ------+--------------------------------------------------------------
// 0     | IDLE       - sequence disabled, PLL held in reset
// 1     | PLL_RESET  - PLL reset asserted for RST_HOLD_CYCLES
// 2     | WAIT_LOCK  - reset released, waiting for qualified lock (timeout)
// 3     | STABLE     - lock seen, must hold for LOCK_STABLE_CYCLES
// 4     | READY      - lane released, monitoring for lock loss
// 5     | FAILED     - retry budget exhausted, waiting for RETRY_CLR
//
// Ports:
//   i_clk          fabric clock, all logic on rising edge
//   i_reset        synchronous active-high reset
//   i_enable       1 = run the sequence, 0 = return to IDLE
//   i_pll_lock     PLL fabric lock (asynchronous)
//   i_lock         PLL lock to lane (asynchronous)
//   i_retry_clr    pulse: clear retry counter / leave FAILED
//   o_pll_rst      active-high reset to PLL/lane datapath
//   o_lane_rst_n   active-low lane reset, released only in READY
//   o_tx_ready     high only in READY
//   o_lock_lost    one-cycle pulse when READY drops due to lock loss
//   o_failed       high only in FAILED
//   o_retry_cnt    failed attempts since last clear, saturating at 15
//   o_state        current state encoding
// -----------------------------------------------------------------------------
module tx_pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_pll_lock,
    input  logic       i_lock,
    input  logic       i_retry_clr,
    output logic       o_pll_rst,
    output logic       o_lane_rst_n,
    output logic       o_tx_ready,
    output logic       o_lock_lost,
    output logic       o_failed,
    output logic [3:0] o_retry_cnt,
    output logic [2:0] o_state
);

    localparam int unsigned MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                                     MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLL_RESET = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_READY     = 3'd4,
        S_FAILED    = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry_cnt;
    logic             r_pll_lock_meta, r_pll_lock_sync;
    logic             r_lock_meta, r_lock_sync;
    logic             r_pll_rst, r_lane_rst_n, r_tx_ready, r_lock_lost, r_failed;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_retry_nxt;
    logic             w_retry_inc;
    logic             w_lock_lost;
    logic             w_qlock;

    // Both lock indications must be up (after synchronisation) to count as lock.
    assign w_qlock = r_pll_lock_sync & r_lock_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_inc = 1'b0;
        w_lock_lost = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = S_PLL_RESET;
                    w_cnt_nxt   = RST_LOAD;
                end
            end
            S_PLL_RESET: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = TIMEOUT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle still wins.
                if (w_qlock) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = STABLE_LOAD;
                end else if (r_cnt == '0) begin
                    w_retry_inc = 1'b1;
                    if (r_retry_cnt >= RETRY_LIMIT) begin
                        w_state_nxt = S_FAILED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_PLL_RESET;
                        w_cnt_nxt   = RST_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_STABLE: begin
                // A dropout here is a glitch: restart the lock wait, no retry.
                if (!w_qlock) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = TIMEOUT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_READY: begin
                if (!w_qlock) begin
                    w_state_nxt = S_PLL_RESET;
                    w_cnt_nxt   = RST_LOAD;
                    w_retry_inc = 1'b1;
                    w_lock_lost = 1'b1;
                end
            end
            S_FAILED: begin
                if (i_retry_clr) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Disable overrides everything except FAILED, which only RETRY_CLR exits.
        if (!i_enable && (r_state != S_FAILED)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_retry_inc = 1'b0;
            w_lock_lost = 1'b0;
        end
    end

    always_comb begin
        w_retry_nxt = r_retry_cnt;
        if (i_retry_clr) begin
            w_retry_nxt = 4'd0;
        end else if (w_retry_inc && (r_retry_cnt != 4'hF)) begin
            w_retry_nxt = r_retry_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pll_lock_meta <= 1'b0;
            r_pll_lock_sync <= 1'b0;
            r_lock_meta     <= 1'b0;
            r_lock_sync     <= 1'b0;
        end else begin
            r_pll_lock_meta <= i_pll_lock;
            r_pll_lock_sync <= r_pll_lock_meta;
            r_lock_meta     <= i_lock;
            r_lock_sync     <= r_lock_meta;
        end
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_retry_cnt  <= 4'd0;
            r_pll_rst    <= 1'b1;
            r_lane_rst_n <= 1'b0;
            r_tx_ready   <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_failed     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_pll_rst    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_PLL_RESET) ||
                            (w_state_nxt == S_FAILED);
            r_lane_rst_n <= (w_state_nxt == S_READY);
            r_tx_ready   <= (w_state_nxt == S_READY);
            r_lock_lost  <= w_lock_lost;
            r_failed     <= (w_state_nxt == S_FAILED);
        end
    end

    assign o_pll_rst    = r_pll_rst;
    assign o_lane_rst_n = r_lane_rst_n;
    assign o_tx_ready   = r_tx_ready;
    assign o_lock_lost  = r_lock_lost;
    assign o_failed     = r_failed;
    assign o_retry_cnt  = r_retry_cnt;
    assign o_state      = r_state;

endmodule

// File: tb/tb_tx_pll_lock_sequencer.sv
module tb_tx_pll_lock_sequencer;

    localparam int RST_HOLD    = 4;
    localparam int TIMEOUT     = 16;
    localparam int STABLE      = 8;
    localparam int MAX_RETRIES = 2;

    localparam int SEL_STATE  = 0;
    localparam int SEL_PLLRST = 1;
    localparam int SEL_LANE   = 2;
    localparam int SEL_TXRDY  = 3;
    localparam int SEL_LOST   = 4;
    localparam int SEL_FAILED = 5;
    localparam int SEL_RETRY  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pll_lock = 1'b0;
    logic       lock = 1'b0;
    logic       retry_clr = 1'b0;
    logic       pll_rst, lane_rst_n, tx_ready, lock_lost, failed;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    typedef struct {
        int    due;
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    tx_pll_lock_sequencer #(
        .RST_HOLD_CYCLES    (RST_HOLD),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT),
        .LOCK_STABLE_CYCLES (STABLE),
        .MAX_RETRIES        (MAX_RETRIES)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_pll_lock  (pll_lock),
        .i_lock      (lock),
        .i_retry_clr (retry_clr),
        .o_pll_rst   (pll_rst),
        .o_lane_rst_n(lane_rst_n),
        .o_tx_ready  (tx_ready),
        .o_lock_lost (lock_lost),
        .o_failed    (failed),
        .o_retry_cnt (retry_cnt),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    function automatic int sample(input int sel);
        case (sel)
            SEL_STATE:  return int'(state);
            SEL_PLLRST: return int'(pll_rst);
            SEL_LANE:   return int'(lane_rst_n);
            SEL_TXRDY:  return int'(tx_ready);
            SEL_LOST:   return int'(lock_lost);
            SEL_FAILED: return int'(failed);
            SEL_RETRY:  return int'(retry_cnt);
            default:    return -2;
        endcase
    endfunction

    // Expect signal 'sel' to equal 'val' k cycles from now.
    task automatic expect_at(input int k, input string tag, input int sel, input int val);
        exp_t e;
        e.due = cyc + k;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, retire due entries.
    task automatic tick();
        int i;
        @(posedge clk);
        #1;
        cyc++;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                chk(sbq[i].tag, (sbq[i].due == cyc) ? sample(sbq[i].sel) : -1, sbq[i].val);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        retry_clr = 1'b0;
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        pll_lock = 1'b1;
        lock     = 1'b1;
        expect_at(2, "rst_state",  SEL_STATE,  0);
        expect_at(2, "rst_pllrst", SEL_PLLRST, 1);
        expect_at(2, "rst_lane",   SEL_LANE,   0);
        expect_at(2, "rst_txrdy",  SEL_TXRDY,  0);
        expect_at(2, "rst_lost",   SEL_LOST,   0);
        expect_at(2, "rst_failed", SEL_FAILED, 0);
        expect_at(2, "rst_retry",  SEL_RETRY,  0);
        do_reset();

        // Test 1: clean bring-up with lock already present
        enable = 1'b1;
        expect_at(1,  "t1_pllrst_c1", SEL_PLLRST, 1);
        expect_at(1,  "t1_state_rst", SEL_STATE,  1);
        expect_at(4,  "t1_pllrst_c4", SEL_PLLRST, 1);
        expect_at(4,  "t1_state_c4",  SEL_STATE,  1);
        expect_at(5,  "t1_pllrst_c5", SEL_PLLRST, 0);
        expect_at(5,  "t1_state_wl",  SEL_STATE,  2);
        expect_at(6,  "t1_state_st",  SEL_STATE,  3);
        expect_at(13, "t1_state_st8", SEL_STATE,  3);
        expect_at(13, "t1_txrdy_pre", SEL_TXRDY,  0);
        expect_at(14, "t1_state_rdy", SEL_STATE,  4);
        expect_at(14, "t1_txrdy",     SEL_TXRDY,  1);
        expect_at(14, "t1_lane",      SEL_LANE,   1);
        expect_at(14, "t1_retry",     SEL_RETRY,  0);
        ticks(14);

        // Test 4: lock loss in READY
        pll_lock = 1'b0;
        expect_at(2, "t4_state_hold", SEL_STATE,  4);
        expect_at(2, "t4_txrdy_hold", SEL_TXRDY,  1);
        expect_at(3, "t4_state_rst",  SEL_STATE,  1);
        expect_at(3, "t4_txrdy",      SEL_TXRDY,  0);
        expect_at(3, "t4_lost",       SEL_LOST,   1);
        expect_at(3, "t4_lane",       SEL_LANE,   0);
        expect_at(3, "t4_pllrst",     SEL_PLLRST, 1);
        expect_at(3, "t4_retry",      SEL_RETRY,  1);
        expect_at(4, "t4_lost_end",   SEL_LOST,   0);
        expect_at(6, "t4_pllrst_c4",  SEL_PLLRST, 1);
        expect_at(7, "t4_pllrst_off", SEL_PLLRST, 0);
        expect_at(7, "t4_state_wl",   SEL_STATE,  2);
        ticks(7);
        pll_lock = 1'b1;
        expect_at(3,  "t4_state_st",  SEL_STATE, 3);
        expect_at(11, "t4_state_rdy", SEL_STATE, 4);
        expect_at(11, "t4_retry_kept", SEL_RETRY, 1);
        ticks(11);
        // RETRY_CLR outside FAILED clears the count only
        retry_clr = 1'b1;
        expect_at(1, "clr_retry", SEL_RETRY, 0);
        expect_at(1, "clr_state", SEL_STATE, 4);
        tick();
        retry_clr = 1'b0;
        tick();

        // Test 3: one-cycle lock glitch while in STABLE
        do_reset();
        enable = 1'b1;
        expect_at(6,  "t3_state_st",   SEL_STATE, 3);
        expect_at(10, "t3_state_st5",  SEL_STATE, 3);
        expect_at(11, "t3_state_wl",   SEL_STATE, 2);
        expect_at(11, "t3_retry",      SEL_RETRY, 0);
        expect_at(12, "t3_state_st2",  SEL_STATE, 3);
        expect_at(19, "t3_state_pre",  SEL_STATE, 3);
        expect_at(19, "t3_txrdy_pre",  SEL_TXRDY, 0);
        expect_at(20, "t3_state_rdy",  SEL_STATE, 4);
        expect_at(20, "t3_txrdy",      SEL_TXRDY, 1);
        ticks(8);
        lock = 1'b0;
        tick();
        lock = 1'b1;
        ticks(11);

        // Test 5a: ENABLE falls on the same cycle qlock falls in READY
        do_reset();
        enable = 1'b1;
        expect_at(14, "t5_state_rdy", SEL_STATE, 4);
        ticks(14);
        pll_lock = 1'b0;
        ticks(2);
        enable = 1'b0;
        expect_at(1, "t5_state_idle", SEL_STATE,  0);
        expect_at(1, "t5_lost",       SEL_LOST,   0);
        expect_at(1, "t5_retry",      SEL_RETRY,  0);
        expect_at(1, "t5_txrdy",      SEL_TXRDY,  0);
        expect_at(1, "t5_pllrst",     SEL_PLLRST, 1);
        expect_at(2, "t5_lost_c2",    SEL_LOST,   0);
        expect_at(2, "t5_state_c2",   SEL_STATE,  0);
        ticks(2);
        pll_lock = 1'b1;

        // Test 2: lock never arrives, retries exhausted
        pll_lock = 1'b0;
        lock     = 1'b0;
        do_reset();
        enable = 1'b1;
        expect_at(20, "t2_state_wl1",  SEL_STATE,  2);
        expect_at(21, "t2_state_rst2", SEL_STATE,  1);
        expect_at(21, "t2_retry1",     SEL_RETRY,  1);
        expect_at(41, "t2_state_rst3", SEL_STATE,  1);
        expect_at(41, "t2_retry2",     SEL_RETRY,  2);
        expect_at(60, "t2_state_wl3",  SEL_STATE,  2);
        expect_at(60, "t2_failed_pre", SEL_FAILED, 0);
        expect_at(61, "t2_state_fail", SEL_STATE,  5);
        expect_at(61, "t2_failed",     SEL_FAILED, 1);
        expect_at(61, "t2_retry3",     SEL_RETRY,  3);
        expect_at(61, "t2_pllrst",     SEL_PLLRST, 1);
        ticks(61);
        // Test 5b: ENABLE=0 ignored in FAILED
        enable = 1'b0;
        expect_at(3, "t5b_state", SEL_STATE,  5);
        expect_at(3, "t5b_failed", SEL_FAILED, 1);
        ticks(3);
        retry_clr = 1'b1;
        expect_at(1, "t2_clr_state",  SEL_STATE,  0);
        expect_at(1, "t2_clr_retry",  SEL_RETRY,  0);
        expect_at(1, "t2_clr_failed", SEL_FAILED, 0);
        tick();
        retry_clr = 1'b0;
        tick();

        // Test 6: RESET pulse mid-WAIT_LOCK with RETRY_CNT=2
        do_reset();
        enable = 1'b1;
        expect_at(45, "t6_state_wl",  SEL_STATE, 2);
        expect_at(47, "t6_retry_pre", SEL_RETRY, 2);
        ticks(47);
        reset = 1'b1;
        expect_at(1, "t6_state_rst", SEL_STATE,  0);
        expect_at(1, "t6_pllrst",    SEL_PLLRST, 1);
        expect_at(1, "t6_retry",     SEL_RETRY,  0);
        tick();
        reset    = 1'b0;
        pll_lock = 1'b1;
        lock     = 1'b1;
        expect_at(1,  "t6_restart",   SEL_STATE, 1);
        expect_at(5,  "t6_state_wl2", SEL_STATE, 2);
        expect_at(6,  "t6_state_st",  SEL_STATE, 3);
        expect_at(14, "t6_state_rdy", SEL_STATE, 4);
        expect_at(14, "t6_txrdy",     SEL_TXRDY, 1);
        expect_at(14, "t6_retry_end", SEL_RETRY, 0);
        ticks(14);

        ticks(2);
        while (sbq.size() > 0) begin
            chk({sbq[0].tag, "_never_sampled"}, -1, sbq[0].val);
            void'(sbq.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
